// File: rtl/alu_checker.sv
`default_nettype none
// ============================================================================
// Module   : alu_checker
// Purpose  : Two-stage response monitor for the 32-bit ALU: golden model,
//            saturating pass/fail tallies and a sticky first-fail snapshot.
//            Optional macro ALU_CHK_STOP_ON_FAIL_EN halts checking on first fail.
// Revision : 1.0  initial release
// ============================================================================
module alu_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            ALUop,
    input  logic [DATA_WIDTH-1:0] Result,
    input  logic                  Overflow,
    input  logic                  CarryOut,
    input  logic                  Zero,
    output logic [CNT_WIDTH-1:0]  pass_cnt,
    output logic [CNT_WIDTH-1:0]  fail_cnt,
    output logic                  err,
    output logic                  halted,
    output logic [2:0]            fail_op,
    output logic [DATA_WIDTH-1:0] fail_a,
    output logic [DATA_WIDTH-1:0] fail_b,
    output logic [DATA_WIDTH-1:0] fail_res,
    output logic [4:0]            fail_mask
);

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b110;
    localparam logic [2:0] c_OP_SLT = 3'b111;

    // Golden model, evaluated on the raw inputs and latched with them
    logic [DATA_WIDTH:0]   w_sum, w_diff;
    logic [DATA_WIDTH-1:0] w_g_res;
    logic                  w_g_ovf, w_g_cout, w_g_chk_flags, w_g_illegal;

    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} + {1'b0, ~B} + {{DATA_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_g_res       = '0;
        w_g_ovf       = 1'b0;
        w_g_cout      = 1'b0;
        w_g_chk_flags = 1'b0;
        w_g_illegal   = 1'b0;
        case (ALUop)
            c_OP_AND: w_g_res = A & B;
            c_OP_OR:  w_g_res = A | B;
            c_OP_ADD: begin
                w_g_res       = w_sum[DATA_WIDTH-1:0];
                w_g_cout      = w_sum[DATA_WIDTH];
                w_g_ovf       = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) &&
                                (w_sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
                w_g_chk_flags = 1'b1;
            end
            c_OP_SUB: begin
                w_g_res       = w_diff[DATA_WIDTH-1:0];
                w_g_cout      = ~w_diff[DATA_WIDTH];   // borrow, i.e. A < B unsigned
                w_g_ovf       = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) &&
                                (w_diff[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
                w_g_chk_flags = 1'b1;
            end
            c_OP_SLT: w_g_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default:  w_g_illegal = 1'b1;
        endcase
    end

    // Stage 1 registers
    logic                  r_s1_valid;
    logic [2:0]            r_s1_op;
    logic [DATA_WIDTH-1:0] r_s1_a, r_s1_b, r_s1_res, r_s1_g_res;
    logic                  r_s1_ovf, r_s1_cout, r_s1_zero;
    logic                  r_s1_g_ovf, r_s1_g_cout, r_s1_chk_flags, r_s1_illegal;

    logic                  w_run, w_cmp, w_fail, w_halt_go;
    logic [4:0]            w_mask;

    always_comb begin
        w_mask = 5'b00000;
        if (r_s1_illegal) begin
            w_mask = 5'b10000;
        end else begin
            w_mask[0] = (r_s1_res != r_s1_g_res);
            w_mask[1] = (r_s1_zero != (r_s1_res == '0));
            w_mask[2] = r_s1_chk_flags && (r_s1_cout != r_s1_g_cout);
            w_mask[3] = r_s1_chk_flags && (r_s1_ovf != r_s1_g_ovf);
        end
    end

    assign w_cmp  = r_s1_valid && w_run && !clear;
    assign w_fail = w_cmp && (w_mask != 5'b00000);

`ifdef ALU_CHK_STOP_ON_FAIL_EN
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;
    logic [0:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_RUN;
        else if (clear)
            r_state <= ST_RUN;
        else if (w_fail)
            r_state <= ST_HALT;
    end

    assign w_run     = (r_state == ST_RUN);
    assign w_halt_go = w_fail;
    assign halted    = (r_state == ST_HALT);
`else
    assign w_run     = 1'b1;
    assign w_halt_go = 1'b0;
    assign halted    = 1'b0;
`endif

    // A capture accompanying clear is kept; samples behind a halting fail are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_op        <= '0;
            r_s1_a         <= '0;
            r_s1_b         <= '0;
            r_s1_res       <= '0;
            r_s1_g_res     <= '0;
            r_s1_ovf       <= 1'b0;
            r_s1_cout      <= 1'b0;
            r_s1_zero      <= 1'b0;
            r_s1_g_ovf     <= 1'b0;
            r_s1_g_cout    <= 1'b0;
            r_s1_chk_flags <= 1'b0;
            r_s1_illegal   <= 1'b0;
        end else begin
            if (clear)
                r_s1_valid <= valid;
            else
                r_s1_valid <= valid && w_run && !w_halt_go;
            if (valid) begin
                r_s1_op        <= ALUop;
                r_s1_a         <= A;
                r_s1_b         <= B;
                r_s1_res       <= Result;
                r_s1_g_res     <= w_g_res;
                r_s1_ovf       <= Overflow;
                r_s1_cout      <= CarryOut;
                r_s1_zero      <= Zero;
                r_s1_g_ovf     <= w_g_ovf;
                r_s1_g_cout    <= w_g_cout;
                r_s1_chk_flags <= w_g_chk_flags;
                r_s1_illegal   <= w_g_illegal;
            end
        end
    end

    // Stage 2: tallies, sticky error and first-fail snapshot
    logic [CNT_WIDTH-1:0]  r_pass_cnt, r_fail_cnt;
    logic                  r_err;
    logic [2:0]            r_fail_op;
    logic [DATA_WIDTH-1:0] r_fail_a, r_fail_b, r_fail_res;
    logic [4:0]            r_fail_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_err       <= 1'b0;
            r_fail_op   <= '0;
            r_fail_a    <= '0;
            r_fail_b    <= '0;
            r_fail_res  <= '0;
            r_fail_mask <= '0;
        end else if (clear) begin
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_err       <= 1'b0;
            r_fail_op   <= '0;
            r_fail_a    <= '0;
            r_fail_b    <= '0;
            r_fail_res  <= '0;
            r_fail_mask <= '0;
        end else if (w_cmp) begin
            if (w_fail) begin
                if (r_fail_cnt != '1)
                    r_fail_cnt <= r_fail_cnt + 1'b1;
                r_err <= 1'b1;
                if (!r_err) begin
                    r_fail_op   <= r_s1_op;
                    r_fail_a    <= r_s1_a;
                    r_fail_b    <= r_s1_b;
                    r_fail_res  <= r_s1_res;
                    r_fail_mask <= w_mask;
                end
            end else if (r_pass_cnt != '1) begin
                r_pass_cnt <= r_pass_cnt + 1'b1;
            end
        end
    end

    assign pass_cnt  = r_pass_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign err       = r_err;
    assign fail_op   = r_fail_op;
    assign fail_a    = r_fail_a;
    assign fail_b    = r_fail_b;
    assign fail_res  = r_fail_res;
    assign fail_mask = r_fail_mask;

endmodule
`default_nettype wire

// File: tb/tb_alu_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_checker
// Purpose  : Directed-vector bench for alu_checker with hand-computed results.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_checker;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          valid = 1'b0;
    logic [DW-1:0] A = '0, B = '0, Result = '0;
    logic [2:0]    ALUop = '0;
    logic          Overflow = 1'b0, CarryOut = 1'b0, Zero = 1'b0;
    logic [CW-1:0] pass_cnt, fail_cnt;
    logic          err, halted;
    logic [2:0]    fail_op;
    logic [DW-1:0] fail_a, fail_b, fail_res;
    logic [4:0]    fail_mask;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .valid(valid),
        .A(A), .B(B), .ALUop(ALUop), .Result(Result),
        .Overflow(Overflow), .CarryOut(CarryOut), .Zero(Zero),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err), .halted(halted),
        .fail_op(fail_op), .fail_a(fail_a), .fail_b(fail_b),
        .fail_res(fail_res), .fail_mask(fail_mask)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one sample at a falling edge; return after its compare edge has passed
    task automatic sample(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] res, input logic ovf, input logic cout, input logic z);
        ALUop = op; A = a; B = b; Result = res;
        Overflow = ovf; CarryOut = cout; Zero = z;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_pass", pass_cnt, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_err", err, 0);
        check("rst_halted", halted, 0);
        check("rst_mask", fail_mask, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD signed overflow, no carry
        sample(3'b010, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
        check("add_ovf_pass", pass_cnt, 1);
        check("add_ovf_err", err, 0);

        // SUB 0-1 borrows
        sample(3'b110, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        check("sub_borrow_pass", pass_cnt, 2);
        sample(3'b110, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        check("sub_cout_fail", fail_cnt, 1);
        check("sub_cout_mask", fail_mask, 5'b00100);
        check("sub_fail_a", fail_a, 0);
        check("sub_fail_b", fail_b, 1);
        check("sub_fail_res", fail_res, 32'hFFFFFFFF);
        check("sub_fail_op", fail_op, 3'b110);
        check("sub_err", err, 1);
`ifdef ALU_CHK_STOP_ON_FAIL_EN
        check("sub_halted", halted, 1);
`else
        check("sub_halted", halted, 0);
`endif

        do_clear();
        check("clr_pass", pass_cnt, 0);
        check("clr_fail", fail_cnt, 0);
        check("clr_err", err, 0);
        check("clr_halted", halted, 0);

        // SLT: flags are don't-care
        sample(3'b111, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b1, 1'b0);
        check("slt_pass", pass_cnt, 1);
        sample(3'b111, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1);
        check("slt_fail_cnt", fail_cnt, 1);
        check("slt_mask", fail_mask, 5'b00001);
        check("slt_fail_op", fail_op, 3'b111);
        // AND golden F000; wrong result and inconsistent Zero
        sample(3'b000, 32'h0000F0F0, 32'h0000FF00, 32'h00001234, 1'b0, 1'b0, 1'b1);
`ifdef ALU_CHK_STOP_ON_FAIL_EN
        check("second_fail_cnt", fail_cnt, 1);
`else
        check("second_fail_cnt", fail_cnt, 2);
`endif
        check("snap_keep_mask", fail_mask, 5'b00001);
        check("snap_keep_op", fail_op, 3'b111);
        check("snap_keep_res", fail_res, 0);

        do_clear();
        sample(3'b101, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0);
        check("illegal_cnt", fail_cnt, 1);
        check("illegal_mask", fail_mask, 5'b10000);
        for (int i = 0; i < 3; i++)
            sample(3'b001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0);
`ifdef ALU_CHK_STOP_ON_FAIL_EN
        check("halt_hold_pass", pass_cnt, 0);
        check("halt_hold_fail", fail_cnt, 1);
        check("halt_state", halted, 1);
        do_clear();
        check("halt_clr_pass", pass_cnt, 0);
        check("halt_clr_fail", fail_cnt, 0);
        check("halt_clr_halted", halted, 0);
`else
        check("run_on_pass", pass_cnt, 3);
        check("run_on_fail", fail_cnt, 1);
        do_clear();
`endif

        // More legal vectors: ADD carry into zero, SUB signed overflow
        sample(3'b010, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b1);
        sample(3'b110, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
        check("carry_ovf_pass", pass_cnt, 2);
        check("carry_ovf_fail", fail_cnt, 0);
        sample(3'b010, 32'h80000000, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0);
        check("add_ovf_mis_mask", fail_mask, 5'b01010);

        // clear on the compare edge discards the in-flight fail
        do_clear();
        ALUop = 3'b101; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        do_clear();
        @(negedge clk);
        check("clr_wins_fail", fail_cnt, 0);
        check("clr_wins_err", err, 0);

        // clear with a new sample on the same edge: sample still counted
        ALUop = 3'b000; A = 32'h0; B = 32'h0; Result = 32'h0; Zero = 1'b1;
        valid = 1'b1; clear = 1'b1;
        @(negedge clk);
        valid = 1'b0; clear = 1'b0;
        @(negedge clk);
        check("clr_and_valid", pass_cnt, 1);

        // Saturation with valid held high
        do_clear();
        ALUop = 3'b000; A = 32'h0; B = 32'h0; Result = 32'h0;
        Overflow = 1'b0; CarryOut = 1'b0; Zero = 1'b1;
        valid = 1'b1;
        repeat ((1 << CW) + 2) @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        check("sat_pass", pass_cnt, 16'hFFFF);
        check("sat_fail", fail_cnt, 0);

        // Create some sticky state, then reset with a sample in stage 1
        sample(3'b001, 32'h5, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
        check("pre_rst_err", err, 1);
        ALUop = 3'b000; A = 32'h0; B = 32'h0; Result = 32'h0; Zero = 1'b1;
        valid = 1'b1;
        @(posedge clk);
        #2;
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_pass", pass_cnt, 0);
        check("async_rst_fail", fail_cnt, 0);
        check("async_rst_err", err, 0);
        check("async_rst_halted", halted, 0);
        check("async_rst_mask", fail_mask, 0);
        check("async_rst_fa", fail_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", pass_cnt, 0);
        sample(3'b000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("post_rst_once", pass_cnt, 1);
        check("post_rst_fail", fail_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
